// File: rtl/iscas_bist_pkg.sv
// Shared definitions for the iscas89 BIST harness.
// Holds the LFSR/MISR feedback polynomial, the controller state type and the
// single-step shift function used by both the pattern generator and the MISR.
package iscas_bist_pkg;

  localparam logic [31:0] POLY = 32'h8020_0003;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } bist_state_t;

  // Right-shifting Galois step: the bit shifted out selects the feedback taps.
  function automatic logic [31:0] step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? POLY : 32'h0);
  endfunction

endpackage

// File: rtl/bist_lfsr32.sv
// 32-bit Galois shift register with parallel fold-in.
// With par_in tied to zero it is a pseudo-random pattern generator; with
// par_in driven by a response vector it acts as a MISR compactor.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (q returns to RST_VAL)
//   load        synchronous load of load_val (wins over en)
//   load_val    value loaded when load is high
//   en          advance one step and xor in par_in
//   par_in      parallel input folded in on each enabled step
//   q           current register value
module bist_lfsr32
  import iscas_bist_pkg::*;
#(
  parameter logic [31:0] RST_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        en,
  input  logic [31:0] par_in,
  output logic [31:0] q
);

  logic [31:0] q_q;
  logic [31:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
      q_d = step(q_q) ^ par_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/iscas_bist_ctrl.sv
// BIST controller wrapped around an iscas89 benchmark core.
// Drives pseudo-random vectors into the core, compacts every response into a
// 32-bit MISR and publishes the final signature with a one-cycle done pulse.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   start        run request, honoured only in IDLE
//   num_vectors  vectors to apply, latched with start
//   dut_in       vector to the core (core-reset bit held high outside RUN)
//   dut_out      combinational core response to the current dut_in
//   busy         high during INIT and RUN
//   done         one-cycle pulse at the end of a run
//   signature    final MISR value, valid with done and held until next run ends
//
// state | meaning
// IDLE  | waiting for start, core held in reset
// INIT  | core reset held for INIT_CYC cycles, generator/MISR seeded
// RUN   | one vector applied and one response folded per cycle
// DONE  | done pulse, MISR copied into the signature register
module iscas_bist_ctrl
  import iscas_bist_pkg::*;
#(
  parameter int          IN_W     = 18,
  parameter int          OUT_W    = 19,
  parameter int          RST_BIT  = 17,
  parameter int          INIT_CYC = 2,
  parameter int          CNT_W    = 16,
  parameter logic [31:0] SEED     = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic [31:0]      signature
);

  localparam int INIT_W = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
  localparam logic [IN_W-1:0] IDLE_VEC = IN_W'(1) << RST_BIT;

  bist_state_t state_q, state_d;

  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  vec_cnt_q, vec_cnt_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic [31:0]       sig_q, sig_d;

  logic        accept;
  logic        run_en;
  logic [31:0] lfsr_q;
  logic [31:0] misr_q;

  // Generator bits above IN_W never reach the core.
  logic unused_lfsr_hi;
  assign unused_lfsr_hi = ^(lfsr_q >> IN_W);

  bist_lfsr32 #(.RST_VAL(SEED)) u_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (SEED),
    .en       (run_en),
    .par_in   (32'h0),
    .q        (lfsr_q)
  );

  bist_lfsr32 #(.RST_VAL(32'h0)) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (32'h0),
    .en       (run_en),
    .par_in   (32'(dut_out)),
    .q        (misr_q)
  );

  // State register and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      vec_cnt_q  <= '0;
      init_cnt_q <= '0;
      sig_q      <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      vec_cnt_q  <= vec_cnt_d;
      init_cnt_q <= init_cnt_d;
      sig_q      <= sig_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = INIT;
      INIT: begin
        if (init_cnt_q == '0) begin
          state_d = (count_q == '0) ? DONE : RUN;
        end
      end
      RUN:  if (vec_cnt_q == count_q - CNT_W'(1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter and signature updates
  always_comb begin
    count_d    = count_q;
    vec_cnt_d  = vec_cnt_q;
    init_cnt_d = init_cnt_q;
    sig_d      = sig_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          count_d    = num_vectors;
          vec_cnt_d  = '0;
          init_cnt_d = INIT_W'(INIT_CYC - 1);
        end
      end
      INIT: begin
        if (init_cnt_q != '0) init_cnt_d = init_cnt_q - INIT_W'(1);
      end
      // Last run cycle leaves vec_cnt at count, which fits in CNT_W bits.
      RUN:  vec_cnt_d = vec_cnt_q + CNT_W'(1);
      DONE: sig_d = misr_q;
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    accept = (state_q == IDLE) && start;
    run_en = (state_q == RUN);
    busy   = (state_q == INIT) || (state_q == RUN);
    done   = (state_q == DONE);
    dut_in = IDLE_VEC;
    if (state_q == RUN) dut_in = lfsr_q[IN_W-1:0] & ~IDLE_VEC;
    // Present the fresh signature alongside the done pulse; the register
    // captures it on the same cycle and holds it afterwards.
    signature = done ? misr_q : sig_q;
  end

endmodule

// File: tb/tb_iscas_bist_ctrl.sv
module tb_iscas_bist_ctrl;

  localparam int          IN_W     = 18;
  localparam int          OUT_W    = 19;
  localparam int          RST_BIT  = 17;
  localparam int          INIT_CYC = 2;
  localparam int          CNT_W    = 16;
  localparam logic [31:0] SEED     = 32'h0000_0001;
  localparam logic [IN_W-1:0] IDLE_VEC = 18'h20000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vectors = '0;
  logic [IN_W-1:0]  dut_in;
  logic [OUT_W-1:0] dut_out;
  logic             busy;
  logic             done;
  logic [31:0]      signature;

  int n_vec = 0;
  int n_err = 0;

  iscas_bist_ctrl #(
    .IN_W(IN_W), .OUT_W(OUT_W), .RST_BIT(RST_BIT),
    .INIT_CYC(INIT_CYC), .CNT_W(CNT_W), .SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vectors(num_vectors),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
    .signature(signature)
  );

  initial forever #5 clk = ~clk;

  // Stand-in sequential core: state cleared while the reset input is high,
  // response is a combinational function of state and current input.
  logic [OUT_W-1:0] core_st = '0;
  logic             tie_en = 1'b1;
  logic [OUT_W-1:0] tie_val = '0;
  logic [OUT_W-1:0] key = '0;

  assign dut_out = tie_en ? tie_val : (core_st ^ {dut_in[0], dut_in} ^ key);

  always @(posedge clk) begin
    if (dut_in[RST_BIT]) core_st <= '0;
    else core_st <= {core_st[OUT_W-2:0], core_st[OUT_W-1]} ^ {1'b0, dut_in};
  end

  function automatic logic [31:0] ref_step(input logic [31:0] x);
    logic [31:0] r;
    r = x >> 1;
    if (x[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is a start time plus a precomputed vector list and
  // final signature; outputs follow from the cycle offset within the run.
  int               edge_count = 0;
  int               t_start = 0;
  int               run_n = 0;
  bit               active = 1'b0;
  logic [31:0]      run_sig = '0;
  logic [31:0]      exp_held = '0;
  logic [IN_W-1:0]  vecs[$];

  task automatic model_edge();
    int rel_now;
    bit was_active;
    logic [31:0] v, m;
    logic [OUT_W-1:0] st, o;
    logic [IN_W-1:0] vin;
    if (!rst_n) begin
      active = 1'b0;
    end else begin
      rel_now = edge_count - t_start;
      was_active = active;
      if (active && rel_now >= 1 + INIT_CYC + run_n) active = 1'b0;
      if (!was_active && start === 1'b1) begin
        t_start = edge_count;
        run_n = int'(num_vectors);
        active = 1'b1;
        v = SEED;
        m = '0;
        st = '0;
        vecs.delete();
        for (int k = 0; k < run_n; k++) begin
          vin = v[IN_W-1:0];
          vin[RST_BIT] = 1'b0;
          o = tie_en ? tie_val : (st ^ {vin[0], vin} ^ key);
          m = ref_step(m) ^ {13'b0, o};
          st = {st[OUT_W-2:0], st[OUT_W-1]} ^ {1'b0, vin};
          vecs.push_back(vin);
          v = ref_step(v);
        end
        run_sig = m;
      end
    end
    edge_count++;
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  // Compare process: every cycle, away from the active edge.
  initial forever begin
    int rel;
    logic [IN_W-1:0] e_in;
    logic e_busy, e_done;
    @(negedge clk);
    e_in = IDLE_VEC;
    e_busy = 1'b0;
    e_done = 1'b0;
    if (!rst_n) begin
      exp_held = '0;
    end else if (active) begin
      rel = edge_count - t_start;
      if (rel >= 1 && rel <= INIT_CYC + run_n) e_busy = 1'b1;
      if (rel >= 1 + INIT_CYC && rel <= INIT_CYC + run_n) e_in = vecs[rel-1-INIT_CYC];
      if (rel == 1 + INIT_CYC + run_n) begin
        e_done = 1'b1;
        exp_held = run_sig;
      end
    end
    chk("cyc_dut_in", 32'(dut_in), 32'(e_in));
    chk("cyc_busy", 32'(busy), 32'(e_busy));
    chk("cyc_done", 32'(done), 32'(e_done));
    chk("cyc_signature", signature, exp_held);
  end

  task automatic do_start(input int n);
    @(negedge clk);
    start = 1'b1;
    num_vectors = CNT_W'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (done === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    chk("done_within_budget", 32'(seen), 32'd1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dut_in", 32'(dut_in), 32'h20000);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_signature", signature, 32'd0);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle_dut_in", 32'(dut_in), 32'h20000);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_signature", signature, 32'd0);

    // N=2, response tied to zero
    tie_en = 1'b1; tie_val = '0;
    do_start(2);
    chk("n2_busy_c1", 32'(busy), 32'd1);
    chk("n2_dut_in_c1", 32'(dut_in), 32'h20000);
    repeat (2) @(negedge clk);
    chk("n2_vec0", 32'(dut_in), 32'h00001);
    @(negedge clk);
    chk("n2_vec1", 32'(dut_in), 32'h00003);
    chk("n2_done_c4", 32'(done), 32'd0);
    @(negedge clk);
    chk("n2_done_c5", 32'(done), 32'd1);
    chk("n2_busy_c5", 32'(busy), 32'd0);
    chk("n2_sig", signature, 32'h0);

    // N=1 and N=2 with response tied to 1
    tie_val = 19'h1;
    do_start(1);
    repeat (3) @(negedge clk);
    chk("n1_done", 32'(done), 32'd1);
    chk("n1_sig", signature, 32'h0000_0001);
    do_start(2);
    repeat (4) @(negedge clk);
    chk("n2b_done", 32'(done), 32'd1);
    chk("n2b_sig", signature, 32'h8020_0002);
    @(negedge clk);
    chk("n2b_sig_held", signature, 32'h8020_0002);

    // N=0: done right after INIT, no vectors, signature cleared
    do_start(0);
    @(negedge clk);
    chk("n0_busy_c2", 32'(busy), 32'd1);
    chk("n0_dut_in_c2", 32'(dut_in), 32'h20000);
    @(negedge clk);
    chk("n0_done_c3", 32'(done), 32'd1);
    chk("n0_sig", signature, 32'h0);

    // Full run, then the same run aborted by reset with a stray start, then again
    tie_en = 1'b0; key = OUT_W'($urandom);
    do_start(20);
    wait_done(40);
    do_start(20);
    repeat (8) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("stray_start_busy", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sig", signature, 32'd0);
    chk("midrst_dut_in", 32'(dut_in), 32'h20000);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    do_start(20);
    wait_done(40);

    // Randomized runs with optional stray starts while busy
    for (int r = 0; r < 12; r++) begin
      int n;
      int p;
      n = $urandom_range(0, 40);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      tie_en = ($urandom_range(0, 3) == 0);
      tie_val = OUT_W'($urandom);
      key = OUT_W'($urandom);
      do_start(n);
      if (n > 0 && $urandom_range(0, 1) == 1) begin
        p = $urandom_range(2, INIT_CYC + n);
        repeat (p - 1) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_done(n + INIT_CYC + 10);
    end

    // Long runs on the stand-in core, back to back
    tie_en = 1'b0; key = OUT_W'($urandom);
    do_start(1000);
    wait_done(1100);
    do_start(1000);
    wait_done(1100);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iscas_bist_ctrl.md
# iscas_bist_ctrl

Built-in self-test harness for the iscas89 benchmark cores (first target: s820, 18 inputs / 19 outputs, input G18 clears its state flops). Sits directly around the benchmark core: upstream it generates pseudo-random input vectors from a 32-bit LFSR; downstream it compacts every output vector into a 32-bit MISR signature. It gives the FPGA flow a single pass/fail number per run.

## Interface
- `IN_W`, 18: width of the vector driven into the core.
- `OUT_W`, 19: width of the core response; `OUT_W` ≤ 32.
- `RST_BIT`, 17: index of the core input that clears core state (G18 on s820).
- `INIT_CYC`, 2: cycles `RST_BIT` is held high before vectors start; ≥1.
- `CNT_W`, 16: width of the vector counter.
- `SEED`, 32'h0000_0001: LFSR start value; nonzero.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  run request; sampled only in IDLE.
- `num_vectors`  in  CNT_W  vectors to apply; latched when `start` is accepted.
- `dut_in`  out  IN_W  vector to the core.
- `dut_out`  in  OUT_W  core response; combinational from the current `dut_in` and core state.
- `busy`  out  1  high in INIT and RUN.
- `done`  out  1  one-cycle pulse at the end of a run.
- `signature`  out  32  MISR value; held stable from `done` until the next accepted `start`.

## Operation
- Step function (shared by LFSR and MISR): `step(x) = (x >> 1) ^ (x[0] ? POLY : 0)`, with `POLY = 32'h8020_0003`.
- Generator: `lfsr <= step(lfsr)` each RUN cycle. `dut_in = lfsr[IN_W-1:0]` with bit `RST_BIT` forced 0.
- MISR: each RUN cycle `misr <= step(misr) ^ zero_extend(dut_out)`.
- FSM states and transitions:
  - IDLE: `dut_in` = only `RST_BIT` set (18'h20000). On `start`: latch `num_vectors`, load `lfsr` = `SEED`, clear `misr` = 0, clear the counter, go to INIT.
  - INIT: drive the IDLE vector for `INIT_CYC` cycles, then go to RUN. If the latched count is 0, go to DONE instead.
  - RUN: apply one vector per cycle and fold one response per cycle. After the cycle with counter = count−1, go to DONE.
  - DONE: assert `done` for one cycle, copy `misr` into `signature`, go to IDLE.
- `start` while `busy` or in DONE is ignored. There is no queuing.
- The counter is CNT_W bits wide. The maximum count is 2^CNT_W−1; the counter never wraps inside a run.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `signature` 0, `lfsr` = `SEED`, `misr` 0, `dut_in` 18'h20000.
- Cycle 0: `start` is sampled high. Cycle 1: `busy` = 1, INIT begins. First vector on `dut_in` at cycle 1+`INIT_CYC`.
- The response to vector k is sampled on the same edge that advances to vector k+1. There is no pipeline lag.
- `done` occurs at cycle 1+`INIT_CYC`+N, and `busy` falls in that same cycle. Total latency from `start` to `done` is `INIT_CYC`+N+1 cycles.
- `rst_n` low mid-run: immediate return to the reset values. No `done` pulse. `signature` is cleared.
- `signature` updates only in DONE.

## Structure
- Package `iscas_bist_pkg` holds:
  - `POLY`
  - the state enum `bist_state_t` (IDLE, INIT, RUN, DONE)
  - the `step` function
- Sub-module `bist_lfsr32` is instantiated twice:
  - `par_in` tied 0 → pattern generator.
  - `par_in` = `dut_out` → MISR.
  - Its ports are `load`, `load_val`, `en`, `par_in`, `q`.
- The top level holds the FSM, the counter, and output forcing.

## Test plan
- Reset with no `start`: `dut_in` = 18'h20000, `busy` = 0, `signature` = 0 indefinitely.
- `start` with N=2, `dut_out` tied 0: `dut_in` = 18'h00001 then 18'h00003. `done` at cycle 5. `signature` = 0.
- N=1, `dut_out` = 19'h1: `signature` = 32'h0000_0001. N=2 with the same input: `signature` = 32'h8020_0002.
- N=0: `done` at cycle 1+`INIT_CYC`, `signature` = 0, no vectors applied.
- `start` pulsed during RUN and `rst_n` pulsed mid-run:
  - the extra `start` is ignored;
  - after reset, state is IDLE, `signature` = 0, no `done`;
  - a fresh run repeats the same signature.
- Connect s820 with N=1000: the signature matches a golden model and is identical across two back-to-back runs.
